// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared FSM state type and layer-geometry helpers for the
// convolution batch sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    WRITE,
    WAIT_OUT,
    DONE
  } state_t;

  localparam int DEF_LENX = 64;
  localparam int DEF_LENF = 33;
  localparam int DEF_P    = 16;

  // Number of valid convolution outputs for an input of lenx and filter of lenf.
  function automatic int calcSize(input int lenx, input int lenf);
    return lenx - lenf + 1;
  endfunction

  // Number of P-wide batches needed to cover size outputs (rounded up).
  function automatic int calcNbatch(input int size, input int p);
    return (size + p - 1) / p;
  endfunction

  // True when value can be represented in an unsigned field of width bits.
  function automatic bit fitsWidth(input int value, input int width);
    return (value >= 0) && (value < (1 << width));
  endfunction

  localparam int SIZE   = calcSize(DEF_LENX, DEF_LENF);
  localparam int NBATCH = calcNbatch(SIZE, DEF_P);

endpackage

// File: rtl/conv_lane_addr_gen.sv
// conv_lane_addr_gen: combinational per-lane X read address generator.
// Lane i reads start+i+k, saturated at the last valid X index so tail
// lanes of a short final batch never wrap back into the buffer.
module conv_lane_addr_gen #(
  parameter int ADDRX = 6,
  parameter int ADDRF = 6,
  parameter int LENX  = 64,
  parameter int P     = 16
) (
  input  logic [ADDRX-1:0]         i_startAddr,
  input  logic [ADDRF-1:0]         i_k,
  output logic [P-1:0][ADDRX-1:0]  o_laneAddr
);

  localparam logic [ADDRX:0]   LIMIT_WIDE = (ADDRX+1)'(LENX - 1);
  localparam logic [ADDRX-1:0] LIMIT      = ADDRX'(LENX - 1);

  logic [ADDRX:0] w_sum;

  // Sum one bit wider than the address so an overrun is visible before the clamp.
  always_comb begin
    w_sum      = '0;
    o_laneAddr = '0;
    for (int i = 0; i < P; i++) begin
      w_sum = (ADDRX+1)'(i_startAddr) + (ADDRX+1)'(i_k) + (ADDRX+1)'(i);
      o_laneAddr[i] = (w_sum > LIMIT_WIDE) ? LIMIT : w_sum[ADDRX-1:0];
    end
  end

endmodule

// File: rtl/conv_batch_sequencer.sv
// conv_batch_sequencer: drives the P-lane convolution datapath for one layer.
// Waits for a full X buffer, then for each batch of P outputs clears the
// accumulators, walks the filter, drains the MAC pipeline, hands the results
// to the output controller and waits for it before the next batch.
// Optional build macro CONV_SEQ_PERF_EN adds a saturating busy_cycles counter.
module conv_batch_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ADDRX   = 6,
  parameter int ADDRF   = 6,
  parameter int LENX    = DEF_LENX,
  parameter int LENF    = DEF_LENF,
  parameter int P       = DEF_P,
  parameter int MAC_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     read_done_x,
  input  logic                     write_done,
  output logic [P-1:0][ADDRX-1:0]  m_addr_read_x,
  output logic [ADDRF-1:0]         m_addr_read_f,
  output logic                     en_acc,
  output logic                     clr_acc,
  output logic                     valid_op,
  output logic [ADDRX-1:0]         start_addr,
  output logic                     conv_done,
  output logic                     all_done
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]              busy_cycles
`endif
);

  localparam int LAYER_SIZE   = calcSize(LENX, LENF);
  localparam int LAYER_NBATCH = calcNbatch(LAYER_SIZE, P);
  localparam int BATCH_W      = $clog2(LAYER_NBATCH + 1);
  localparam int DRAIN_W      = $clog2(MAC_LAT + 1);

  localparam logic [ADDRF-1:0]   K_LAST     = ADDRF'(LENF - 1);
  localparam logic [ADDRX-1:0]   P_STEP     = ADDRX'(P);
  localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(LAYER_NBATCH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MAC_LAT - 1);

  if (!fitsWidth(LENX - 1, ADDRX)) begin : g_badAddrx
    $error("conv_batch_sequencer: ADDRX cannot hold LENX-1");
  end
  if (!fitsWidth(LENF - 1, ADDRF)) begin : g_badAddrf
    $error("conv_batch_sequencer: ADDRF cannot hold LENF-1");
  end
  if (MAC_LAT < 1) begin : g_badLat
    $error("conv_batch_sequencer: MAC_LAT must be at least 1");
  end
  if ((LENX == DEF_LENX) && (LENF == DEF_LENF) && (P == DEF_P) &&
      ((LAYER_SIZE != SIZE) || (LAYER_NBATCH != NBATCH))) begin : g_badDefaults
    $error("conv_batch_sequencer: default geometry disagrees with conv_seq_pkg");
  end

  state_t                r_state;
  logic [ADDRF-1:0]      r_k;
  logic [DRAIN_W-1:0]    r_drain;
  logic [BATCH_W-1:0]    r_batch;
  logic [ADDRX-1:0]      r_startAddr;
  logic                  r_laneEn;
  logic                  r_clrAcc;
  logic                  r_validOp;
  logic                  r_allDone;
  logic [MAC_LAT-1:0]    r_enPipe;
  logic [P-1:0][ADDRX-1:0] w_laneAddr;
  logic                  w_runValid;

  assign w_runValid = (r_state == RUN);

  // Layer/batch sequencing FSM; pulse outputs are set on the edge entering their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_drain     <= '0;
      r_batch     <= '0;
      r_startAddr <= '0;
      r_laneEn    <= 1'b0;
      r_clrAcc    <= 1'b0;
      r_validOp   <= 1'b0;
      r_allDone   <= 1'b0;
    end else begin
      r_clrAcc  <= 1'b0;
      r_validOp <= 1'b0;
      r_allDone <= 1'b0;
      case (r_state)
        IDLE: begin
          if (read_done_x) begin
            r_startAddr <= '0;
            r_batch     <= '0;
            r_laneEn    <= 1'b1;
            r_clrAcc    <= 1'b1;
            r_state     <= CLEAR;
          end
        end
        CLEAR: begin
          r_k     <= '0;
          r_state <= RUN;
        end
        RUN: begin
          if (r_k == K_LAST) begin
            r_drain <= '0;
            r_state <= DRAIN;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_validOp <= 1'b1;
            r_state   <= WRITE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        WRITE: begin
          r_state <= WAIT_OUT;
        end
        WAIT_OUT: begin
          if (write_done) begin
            if (r_batch == BATCH_LAST) begin
              r_allDone <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_batch     <= r_batch + 1'b1;
              r_startAddr <= r_startAddr + P_STEP;
              r_clrAcc    <= 1'b1;
              r_state     <= CLEAR;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Delay the RUN flag by the memory-plus-MAC-input latency to line up with operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enPipe <= '0;
    end else begin
      r_enPipe <= MAC_LAT'({r_enPipe, w_runValid});
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] r_busyCycles;

  // Saturating count of non-idle cycles, restarted whenever a new layer begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busyCycles <= '0;
    end else if ((r_state == IDLE) && read_done_x) begin
      r_busyCycles <= '0;
    end else if ((r_state != IDLE) && (r_busyCycles != 32'hFFFF_FFFF)) begin
      r_busyCycles <= r_busyCycles + 32'd1;
    end
  end

  assign busy_cycles = r_busyCycles;
`endif

  conv_lane_addr_gen #(
    .ADDRX (ADDRX),
    .ADDRF (ADDRF),
    .LENX  (LENX),
    .P     (P)
  ) u_laneAddr (
    .i_startAddr (r_startAddr),
    .i_k         (r_k),
    .o_laneAddr  (w_laneAddr)
  );

  // Lane addresses read as zero until the first layer starts after reset.
  assign m_addr_read_x = r_laneEn ? w_laneAddr : '0;
  assign m_addr_read_f = r_k;
  assign en_acc        = r_enPipe[MAC_LAT-1];
  assign clr_acc       = r_clrAcc;
  assign valid_op      = r_validOp;
  assign conv_done     = r_validOp;
  assign start_addr    = r_startAddr;
  assign all_done      = r_allDone;

endmodule

// File: tb/tb_conv_batch_sequencer.sv
// tb_conv_batch_sequencer: directed layer runs with randomized ignored inputs
// and wait lengths, checked against a per-cycle schedule computed from the
// layer geometry. Instance A uses the default geometry, instance B a short
// layer (LENX=41, LENF=9) whose last batch exercises lane saturation.
module tb_conv_batch_sequencer;

  localparam int ADDRX   = 6;
  localparam int ADDRF   = 6;
  localparam int P       = 16;
  localparam int MAC_LAT = 2;
  localparam int LENX_A  = 64;
  localparam int LENF_A  = 33;
  localparam int LENX_B  = 41;
  localparam int LENF_B  = 9;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic rdA = 1'b0, wdA = 1'b0, rdB = 1'b0, wdB = 1'b0;

  logic [P-1:0][ADDRX-1:0] addrXA, addrXB;
  logic [ADDRF-1:0]        addrFA, addrFB;
  logic                    enA, clrA, validA, convA, allA;
  logic                    enB, clrB, validB, convB, allB;
  logic [ADDRX-1:0]        startA, startB;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]             busyA, busyB;
`endif

  logic [P-1:0][ADDRX-1:0] obsX;
  logic [ADDRF-1:0]        obsF;
  logic                    obsEn, obsClr, obsValid, obsConv, obsAll;
  logic [ADDRX-1:0]        obsStart;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]             obsBusy;
`endif

  int checks = 0;
  int errors = 0;

  conv_batch_sequencer #(
    .ADDRX(ADDRX), .ADDRF(ADDRF), .LENX(LENX_A), .LENF(LENF_A), .P(P), .MAC_LAT(MAC_LAT)
  ) u_dutA (
    .clk           (clk),
    .reset         (reset),
    .read_done_x   (rdA),
    .write_done    (wdA),
    .m_addr_read_x (addrXA),
    .m_addr_read_f (addrFA),
    .en_acc        (enA),
    .clr_acc       (clrA),
    .valid_op      (validA),
    .start_addr    (startA),
    .conv_done     (convA),
    .all_done      (allA)
`ifdef CONV_SEQ_PERF_EN
    ,
    .busy_cycles   (busyA)
`endif
  );

  conv_batch_sequencer #(
    .ADDRX(ADDRX), .ADDRF(ADDRF), .LENX(LENX_B), .LENF(LENF_B), .P(P), .MAC_LAT(MAC_LAT)
  ) u_dutB (
    .clk           (clk),
    .reset         (reset),
    .read_done_x   (rdB),
    .write_done    (wdB),
    .m_addr_read_x (addrXB),
    .m_addr_read_f (addrFB),
    .en_acc        (enB),
    .clr_acc       (clrB),
    .valid_op      (validB),
    .start_addr    (startB),
    .conv_done     (convB),
    .all_done      (allB)
`ifdef CONV_SEQ_PERF_EN
    ,
    .busy_cycles   (busyB)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value and count the outcome.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive the handshake inputs of the selected instance; the other one sees zeros.
  task automatic applyStimulus(input int which, input logic rd, input logic wd);
    rdA = (which == 0) ? rd : 1'b0;
    wdA = (which == 0) ? wd : 1'b0;
    rdB = (which == 1) ? rd : 1'b0;
    wdB = (which == 1) ? wd : 1'b0;
  endtask

  // Copy the selected instance's outputs into the obs* variables.
  task automatic sample(input int which);
    if (which == 0) begin
      obsX = addrXA; obsF = addrFA; obsEn = enA; obsClr = clrA;
      obsValid = validA; obsConv = convA; obsAll = allA; obsStart = startA;
`ifdef CONV_SEQ_PERF_EN
      obsBusy = busyA;
`endif
    end else begin
      obsX = addrXB; obsF = addrFB; obsEn = enB; obsClr = clrB;
      obsValid = validB; obsConv = convB; obsAll = allB; obsStart = startB;
`ifdef CONV_SEQ_PERF_EN
      obsBusy = busyB;
`endif
    end
  endtask

  // Reference lane address: start + lane + k, saturated at the last X index.
  function automatic int expLane(input int base, input int lane, input int k, input int lenx);
    int v;
    v = base + lane + k;
    return (v > lenx - 1) ? lenx - 1 : v;
  endfunction

  // Run one full layer starting in an IDLE cycle; returns in the all_done cycle.
  task automatic runLayer(input int which, input int lenx, input int lenf, input bit holdRd,
                          input int waitFixed, output int busyExp);
    int nb, base, k, lane, w, lastOff;
    nb      = ((lenx - lenf + 1) + P - 1) / P;
    lastOff = lenf + MAC_LAT + 1;
    busyExp = 1;
    applyStimulus(which, 1'b1, 1'b0);
    for (int b = 0; b < nb; b++) begin
      base = b * P;
      for (int o = 0; o <= lastOff; o++) begin
        tick();
        applyStimulus(which, holdRd ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        sample(which);
        checkOutput("clr_acc", 64'(obsClr), 64'(o == 0));
        checkOutput("start_addr", 64'(obsStart), 64'(base));
        checkOutput("en_acc", 64'(obsEn), 64'((o >= 1 + MAC_LAT) && (o <= lenf + MAC_LAT)));
        checkOutput("valid_op", 64'(obsValid), 64'(o == lastOff));
        checkOutput("conv_done", 64'(obsConv), 64'(o == lastOff));
        checkOutput("all_done", 64'(obsAll), 64'd0);
        if (o >= 1) begin
          k = (o <= lenf) ? o - 1 : lenf - 1;
          lane = $urandom_range(0, P - 1);
          checkOutput("addr_f", 64'(obsF), 64'(k));
          checkOutput("lane5_addr", 64'(obsX[5]), 64'(expLane(base, 5, k, lenx)));
          checkOutput("lane15_addr", 64'(obsX[P-1]), 64'(expLane(base, P - 1, k, lenx)));
          checkOutput("laneRand_addr", 64'(obsX[lane]), 64'(expLane(base, lane, k, lenx)));
        end
      end
      w = (waitFixed > 0) ? waitFixed : $urandom_range(1, 12);
      for (int j = 0; j < w; j++) begin
        tick();
        applyStimulus(which, holdRd ? 1'b1 : 1'($urandom_range(0, 1)), 1'(j == w - 1));
        sample(which);
        checkOutput("wait_valid_op", 64'(obsValid), 64'd0);
        checkOutput("wait_clr_acc", 64'(obsClr), 64'd0);
        checkOutput("wait_en_acc", 64'(obsEn), 64'd0);
        checkOutput("wait_all_done", 64'(obsAll), 64'd0);
        checkOutput("wait_start_addr", 64'(obsStart), 64'(base));
      end
      busyExp += lastOff + 1 + w;
    end
    tick();
    applyStimulus(which, holdRd, 1'($urandom_range(0, 1)));
    sample(which);
    checkOutput("done_all_done", 64'(obsAll), 64'd1);
    checkOutput("done_valid_op", 64'(obsValid), 64'd0);
    checkOutput("done_clr_acc", 64'(obsClr), 64'd0);
  endtask

  // Check the first IDLE cycle after a layer.
  task automatic checkIdleAfter(input int which, input int busyExp);
    tick();
    sample(which);
    checkOutput("idle_all_done", 64'(obsAll), 64'd0);
    checkOutput("idle_clr_acc", 64'(obsClr), 64'd0);
    checkOutput("idle_valid_op", 64'(obsValid), 64'd0);
`ifdef CONV_SEQ_PERF_EN
    checkOutput("busy_cycles", 64'(obsBusy), 64'(busyExp));
`else
    if (busyExp < 0) $display("[TB] unexpected negative busy estimate");
`endif
  endtask

  initial begin
    int busyExp;
    int pulses;

    // Reset state of both instances.
    #2;
    sample(0);
    checkOutput("rst_addr_x", 64'(obsX), 64'd0);
    checkOutput("rst_addr_f", 64'(obsF), 64'd0);
    checkOutput("rst_outputs", 64'({obsEn, obsClr, obsValid, obsConv, obsAll}), 64'd0);
    checkOutput("rst_start_addr", 64'(obsStart), 64'd0);
    sample(1);
    checkOutput("rstB_addr_x", 64'(obsX), 64'd0);
    tick();
    reset = 1'b0;

    $display("[TB] layer A with 10-cycle output hold");
    runLayer(0, LENX_A, LENF_A, 1'b0, 10, busyExp);
    applyStimulus(0, 1'b0, 1'b0);
    checkIdleAfter(0, busyExp);

    // No request: nothing should start.
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      applyStimulus(0, 1'b0, 1'($urandom_range(0, 1)));
      sample(0);
      pulses += int'(obsClr);
    end
    checkOutput("idle_no_start", 64'(pulses), 64'd0);

    $display("[TB] reset during RUN");
    applyStimulus(0, 1'b1, 1'b0);
    for (int c = 0; c < 22; c++) begin
      tick();
      applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    sample(0);
    checkOutput("pre_abort_addr_f", 64'(obsF), 64'd20);
    #2;
    reset = 1'b1;
    #1;
    sample(0);
    checkOutput("abort_addr_x", 64'(obsX), 64'd0);
    checkOutput("abort_addr_f", 64'(obsF), 64'd0);
    checkOutput("abort_outputs", 64'({obsEn, obsClr, obsValid, obsConv, obsAll}), 64'd0);
    checkOutput("abort_start_addr", 64'(obsStart), 64'd0);
    tick();
    reset = 1'b0;
    applyStimulus(0, 1'b0, 1'b0);
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      applyStimulus(0, 1'b0, 1'($urandom_range(0, 1)));
      sample(0);
      pulses += int'(obsValid) + int'(obsAll) + int'(obsEn) + int'(obsClr);
    end
    checkOutput("abort_no_pulses", 64'(pulses), 64'd0);
    runLayer(0, LENX_A, LENF_A, 1'b0, 0, busyExp);
    applyStimulus(0, 1'b0, 1'b0);
    checkIdleAfter(0, busyExp);

    $display("[TB] back-to-back layers with read_done_x held");
    runLayer(0, LENX_A, LENF_A, 1'b1, 0, busyExp);
    checkIdleAfter(0, busyExp);
    runLayer(0, LENX_A, LENF_A, 1'b1, 0, busyExp);
    applyStimulus(0, 1'b0, 1'b0);
    checkIdleAfter(0, busyExp);

    $display("[TB] short layer B with saturating tail batch");
    runLayer(1, LENX_B, LENF_B, 1'b0, 0, busyExp);
    applyStimulus(1, 1'b0, 1'b0);
    checkIdleAfter(1, busyExp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
